// File: rtl/ysyx_22051013_id_scoreboard_pkg.sv
// rtl/ysyx_22051013_id_scoreboard_pkg.sv - shared widths, zero constant and bypass-channel packing helpers
package ysyx_22051013_id_scoreboard_pkg;

  localparam int          NREG_DEF = 32;
  localparam int          REG_AW   = $clog2(NREG_DEF);
  localparam int          NFWD_DEF = 3;
  localparam logic [63:0] ZERO64   = 64'd0;

  // Channel 0 sits in the least-significant slice and is the youngest, highest-priority source.
  function automatic int fwd_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/ysyx_22051013_sb_fwd_sel.sv
// rtl/ysyx_22051013_sb_fwd_sel.sv - one operand's bypass priority select with pending/lw-hit flags
module ysyx_22051013_sb_fwd_sel
  import ysyx_22051013_id_scoreboard_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = REG_AW,
  parameter int NFWD = NFWD_DEF
) (
  input  logic                 ena,
  input  logic [AW-1:0]        addr,
  input  logic [XLEN-1:0]      rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_pending,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 lw_done,
  input  logic [AW-1:0]        lw_addr,
  input  logic [XLEN-1:0]      lw_data,
  output logic [XLEN-1:0]      data,
  output logic                 fwd_pend,
  output logic                 lw_hit
);

  always_comb begin
    data     = XLEN'(ZERO64);
    fwd_pend = 1'b0;
    lw_hit   = 1'b0;
    if (ena && addr != '0) begin
      data = rdata;
      if (lw_done && lw_addr == addr) begin
        data   = lw_data;
        lw_hit = 1'b1;
      end
      // Walk from oldest to youngest so the lowest-index match is written last and wins.
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_valid[i] && fwd_addr[fwd_lsb(i, AW) +: AW] == addr) begin
          data     = fwd_data[fwd_lsb(i, XLEN) +: XLEN];
          fwd_pend = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_22051013_id_scoreboard.sv
// rtl/ysyx_22051013_id_scoreboard.sv - ID operand resolution, busy scoreboard and issue gating; optional watchdog via YSYX_22051013_SB_WATCHDOG_EN
module ysyx_22051013_id_scoreboard
  import ysyx_22051013_id_scoreboard_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int NREG      = NREG_DEF,
  parameter int NFWD      = NFWD_DEF,
  parameter int STALL_MAX = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic                         ex_ready,
  input  logic                         flush,
  output logic                         id_fire,
  output logic                         id_stall,
  input  logic                         rs1_ena,
  input  logic                         rs2_ena,
  input  logic [$clog2(NREG)-1:0]      rs1_addr,
  input  logic [$clog2(NREG)-1:0]      rs2_addr,
  input  logic [XLEN-1:0]              rs1_rdata,
  input  logic [XLEN-1:0]              rs2_rdata,
  input  logic                         rd_ena,
  input  logic [$clog2(NREG)-1:0]      rd_addr,
  input  logic                         long_op,
  input  logic [NFWD-1:0]              fwd_valid,
  input  logic [NFWD-1:0]              fwd_pending,
  input  logic [NFWD*$clog2(NREG)-1:0] fwd_addr,
  input  logic [NFWD*XLEN-1:0]         fwd_data,
  input  logic                         lw_done,
  input  logic [$clog2(NREG)-1:0]      lw_addr,
  input  logic [XLEN-1:0]              lw_data,
  output logic [XLEN-1:0]              op1,
  output logic [XLEN-1:0]              op2,
  output logic [NREG-1:0]              busy_o,
  output logic                         sb_timeout
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0] busy, busy_nxt;
  logic            pend1, pend2, lw_hit1, lw_hit2;
  logic            act1, act2, raw1, raw2, waw, sb_set;

  ysyx_22051013_sb_fwd_sel #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_sel_rs1 (
    .ena(rs1_ena), .addr(rs1_addr), .rdata(rs1_rdata),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .lw_done(lw_done), .lw_addr(lw_addr), .lw_data(lw_data),
    .data(op1), .fwd_pend(pend1), .lw_hit(lw_hit1)
  );

  ysyx_22051013_sb_fwd_sel #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_sel_rs2 (
    .ena(rs2_ena), .addr(rs2_addr), .rdata(rs2_rdata),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .lw_done(lw_done), .lw_addr(lw_addr), .lw_data(lw_data),
    .data(op2), .fwd_pend(pend2), .lw_hit(lw_hit2)
  );

  assign act1 = rs1_ena && rs1_addr != '0;
  assign act2 = rs2_ena && rs2_addr != '0;
  assign raw1 = act1 && (pend1 || (busy[rs1_addr] && !lw_hit1));
  assign raw2 = act2 && (pend2 || (busy[rs2_addr] && !lw_hit2));
  // A short writer must also wait, otherwise a bypass channel could later target a busy register.
  assign waw  = rd_ena && rd_addr != '0 && busy[rd_addr] && !(lw_done && lw_addr == rd_addr);

  assign id_stall = id_valid && (raw1 || raw2 || waw) && !flush;
  assign id_fire  = id_valid && !id_stall && ex_ready && !flush;
  assign sb_set   = id_fire && long_op && rd_ena && rd_addr != '0;

  // Set is applied after clear: the issuing instruction is younger than the completing writer.
  always_comb begin
    busy_nxt = busy;
    if (lw_done) busy_nxt[lw_addr] = 1'b0;
    if (sb_set)  busy_nxt[rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign busy_o = busy;

`ifdef YSYX_22051013_SB_WATCHDOG_EN
  localparam int CW = $clog2(STALL_MAX + 1);

  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic          wd_to;

  always_comb begin
    wd_cnt_nxt = '0;
    if (id_stall) wd_cnt_nxt = (wd_cnt == CW'(STALL_MAX)) ? wd_cnt : wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      wd_to  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_nxt;
      if (wd_cnt_nxt == CW'(STALL_MAX)) wd_to <= 1'b1;
    end
  end

  assign sb_timeout = wd_to;
`else
  logic stall_max_unused;
  assign stall_max_unused = (STALL_MAX != 0);
  assign sb_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22051013_id_scoreboard.sv
// tb/tb_ysyx_22051013_id_scoreboard.sv - self-checking bench: vector table, hazard sequences, random vs reference model
module tb_ysyx_22051013_id_scoreboard;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, ex_ready, flush, id_fire, id_stall;
  logic        rs1_ena, rs2_ena, rd_ena, long_op, lw_done;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, lw_addr;
  logic [63:0] rs1_rdata, rs2_rdata, lw_data, op1, op2;
  logic [2:0]  fwd_valid, fwd_pending;
  logic [4:0]  fa [3];
  logic [63:0] fd [3];
  logic [31:0] busy_o;
  logic        sb_timeout;

  logic [14:0]  fwd_addr;
  logic [191:0] fwd_data;
  assign fwd_addr = {fa[2], fa[1], fa[0]};
  assign fwd_data = {fd[2], fd[1], fd[0]};

  ysyx_22051013_id_scoreboard #(.XLEN(64), .NREG(32), .NFWD(3), .STALL_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .ex_ready(ex_ready), .flush(flush),
    .id_fire(id_fire), .id_stall(id_stall), .rs1_ena(rs1_ena), .rs2_ena(rs2_ena),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .rd_ena(rd_ena), .rd_addr(rd_addr), .long_op(long_op), .fwd_valid(fwd_valid),
    .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .lw_done(lw_done),
    .lw_addr(lw_addr), .lw_data(lw_data), .op1(op1), .op2(op2), .busy_o(busy_o),
    .sb_timeout(sb_timeout)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] mbusy;
  int          wd_cnt;
  bit          wd_to;

  typedef struct {
    string       name;
    bit          v, exr, fl, r1e;
    logic [4:0]  r1a;
    bit          r2e;
    logic [4:0]  r2a;
    logic [2:0]  fv, fp;
    logic [4:0]  fa0, fa1, fa2;
    logic [63:0] fd0, fd1, fd2;
    bit          lwd;
    logic [4:0]  lwa;
    logic [63:0] lwdat;
    logic [63:0] e_op1, e_op2;
    bit          e_stall, e_fire;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; ex_ready = 1; flush = 0; rs1_ena = 0; rs2_ena = 0; rd_ena = 0; long_op = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; lw_done = 0; lw_addr = 0; lw_data = 0;
    rs1_rdata = 64'h1111; rs2_rdata = 64'h2222; fwd_valid = 0; fwd_pending = 0;
    for (int i = 0; i < 3; i++) begin fa[i] = 0; fd[i] = 0; end
  endtask

  // Reference operand lookup: scan channels youngest-first, stop at the first hit.
  task automatic resolve(input bit ena, input logic [4:0] a, input logic [63:0] rdata,
                         output logic [63:0] d, output bit blk);
    bit found = 0;
    d = 0; blk = 0;
    if (ena && a != 0) begin
      d = rdata;
      for (int ch = 0; ch < 3; ch++)
        if (!found && fwd_valid[ch] && fa[ch] == a) begin
          found = 1; d = fd[ch]; blk = fwd_pending[ch];
        end
      if (!found && lw_done && lw_addr == a) d = lw_data;
      if (mbusy[a] && !(lw_done && lw_addr == a)) blk = 1;
    end
  endtask

  task automatic run_cycle(input string nm);
    logic [63:0] e1, e2;
    bit b1, b2, waw, est, efire, eto;
    #1;
    resolve(rs1_ena, rs1_addr, rs1_rdata, e1, b1);
    resolve(rs2_ena, rs2_addr, rs2_rdata, e2, b2);
    waw   = rd_ena && rd_addr != 0 && mbusy[rd_addr] && !(lw_done && lw_addr == rd_addr);
    est   = id_valid && !flush && (b1 || b2 || waw);
    efire = id_valid && !flush && !est && ex_ready;
`ifdef YSYX_22051013_SB_WATCHDOG_EN
    eto = wd_to;
`else
    eto = 0;
`endif
    chk($sformatf("%s.op1", nm), op1, e1);
    chk($sformatf("%s.op2", nm), op2, e2);
    chk($sformatf("%s.stall", nm), 64'(id_stall), 64'(est));
    chk($sformatf("%s.fire", nm), 64'(id_fire), 64'(efire));
    chk($sformatf("%s.busy", nm), 64'(busy_o), 64'(mbusy));
    chk($sformatf("%s.timeout", nm), 64'(sb_timeout), 64'(eto));
    @(posedge clk);
    if (lw_done) mbusy[lw_addr] = 0;
    if (efire && long_op && rd_ena && rd_addr != 0) mbusy[rd_addr] = 1;
    wd_cnt = est ? ((wd_cnt + 1 > SMAX) ? SMAX : wd_cnt + 1) : 0;
    if (wd_cnt == SMAX) wd_to = 1;
    #1;
  endtask

  task automatic model_reset();
    mbusy = 0; wd_cnt = 0; wd_to = 0;
  endtask

  initial begin
    vecs[0]  = '{"fwd_prio",    1,1,0, 1,5, 0,0, 3'b101,3'b000, 5,0,5, 64'hA,0,64'hC, 0,0,0, 64'hA,0,0,1};
    vecs[1]  = '{"load_use",    1,1,0, 0,0, 1,7, 3'b001,3'b001, 7,0,0, 64'h55,0,0, 0,0,0, 0,64'h55,1,0};
    vecs[2]  = '{"load_ready",  1,1,0, 0,0, 1,7, 3'b001,3'b000, 7,0,0, 64'h55,0,0, 0,0,0, 0,64'h55,0,1};
    vecs[3]  = '{"x0_fwd",      1,1,0, 1,0, 0,0, 3'b001,3'b001, 0,0,0, 64'h77,0,0, 0,0,0, 0,0,0,1};
    vecs[4]  = '{"flush",       1,1,1, 0,0, 1,7, 3'b001,3'b001, 7,0,0, 64'h55,0,0, 0,0,0, 0,64'h55,0,0};
    vecs[5]  = '{"ex_not_rdy",  1,0,0, 1,4, 1,6, 3'b000,3'b000, 0,0,0, 0,0,0, 0,0,0, 64'h1111,64'h2222,0,0};
    vecs[6]  = '{"lw_bypass",   1,1,0, 1,9, 0,0, 3'b000,3'b000, 0,0,0, 0,0,0, 1,9,64'h1234, 64'h1234,0,0,1};
    vecs[7]  = '{"fwd_over_lw", 1,1,0, 1,9, 0,0, 3'b010,3'b000, 0,9,0, 0,64'hB,0, 1,9,64'h1234, 64'hB,0,0,1};
    vecs[8]  = '{"regfile",     1,1,0, 1,4, 1,6, 3'b000,3'b000, 0,0,0, 0,0,0, 0,0,0, 64'h1111,64'h2222,0,1};
    vecs[9]  = '{"young_ready", 1,1,0, 1,3, 0,0, 3'b011,3'b010, 3,3,0, 64'hD,64'hE,0, 0,0,0, 64'hD,0,0,1};
    vecs[10] = '{"no_valid",    0,1,0, 0,0, 1,7, 3'b001,3'b001, 7,0,0, 64'h55,0,0, 0,0,0, 0,64'h55,0,0};
    vecs[11] = '{"ch2_both",    1,1,0, 1,8, 1,8, 3'b100,3'b000, 0,0,8, 0,0,64'hF, 0,0,0, 64'hF,64'hF,0,1};

    idle();
    model_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy_o), 0);
    chk("reset.timeout", 64'(sb_timeout), 0);
    rst = 1;

    for (int k = 0; k < 12; k++) begin
      idle();
      id_valid = vecs[k].v; ex_ready = vecs[k].exr; flush = vecs[k].fl;
      rs1_ena = vecs[k].r1e; rs1_addr = vecs[k].r1a; rs2_ena = vecs[k].r2e; rs2_addr = vecs[k].r2a;
      fwd_valid = vecs[k].fv; fwd_pending = vecs[k].fp;
      fa[0] = vecs[k].fa0; fa[1] = vecs[k].fa1; fa[2] = vecs[k].fa2;
      fd[0] = vecs[k].fd0; fd[1] = vecs[k].fd1; fd[2] = vecs[k].fd2;
      lw_done = vecs[k].lwd; lw_addr = vecs[k].lwa; lw_data = vecs[k].lwdat;
      #1;
      chk({vecs[k].name, ".op1"}, op1, vecs[k].e_op1);
      chk({vecs[k].name, ".op2"}, op2, vecs[k].e_op2);
      chk({vecs[k].name, ".stall"}, 64'(id_stall), 64'(vecs[k].e_stall));
      chk({vecs[k].name, ".fire"}, 64'(id_fire), 64'(vecs[k].e_fire));
      run_cycle(vecs[k].name);
    end

    // Long op issue, dependent stall, release on the completing writeback.
    idle(); id_valid = 1; rd_ena = 1; rd_addr = 9; long_op = 1;
    run_cycle("div_issue");
    chk("div.busy9_set", 64'(busy_o[9]), 1);
    idle(); id_valid = 1; rs1_ena = 1; rs1_addr = 9;
    #1 chk("div.cons_stall", 64'(id_stall), 1);
    run_cycle("div_wait");
    lw_done = 1; lw_addr = 9; lw_data = 64'h1234;
    #1 chk("div.wake_op1", op1, 64'h1234);
    chk("div.wake_fire", 64'(id_fire), 1);
    run_cycle("div_wake");
    chk("div.busy9_clr", 64'(busy_o[9]), 0);

    // WAW on a busy reg, then same-cycle set and clear of that reg.
    idle(); id_valid = 1; rd_ena = 1; rd_addr = 3; long_op = 1;
    run_cycle("x3_issue");
    idle(); id_valid = 1; rd_ena = 1; rd_addr = 3;
    #1 chk("waw.stall", 64'(id_stall), 1);
    run_cycle("waw");
    idle(); id_valid = 1; rd_ena = 1; rd_addr = 3; long_op = 1; lw_done = 1; lw_addr = 3; lw_data = 64'h33;
    #1 chk("setclr.fire", 64'(id_fire), 1);
    run_cycle("setclr");
    chk("setclr.busy3", 64'(busy_o[3]), 1);

    // Flush over a busy-reg hazard: no stall, no issue, scoreboard untouched.
    idle(); id_valid = 1; flush = 1; rs1_ena = 1; rs1_addr = 3;
    #1 chk("flush.stall", 64'(id_stall), 0);
    chk("flush.fire", 64'(id_fire), 0);
    run_cycle("flush_busy");
    chk("flush.busy3", 64'(busy_o[3]), 1);
    idle(); lw_done = 1; lw_addr = 3;
    run_cycle("x3_drain");
    idle(); lw_done = 1; lw_addr = 21;
    run_cycle("lw_nonbusy");

    // Watchdog: stall on busy x12 for STALL_MAX cycles, then reset mid-operation.
    idle(); id_valid = 1; rd_ena = 1; rd_addr = 12; long_op = 1;
    run_cycle("x12_issue");
    idle(); id_valid = 1; rs2_ena = 1; rs2_addr = 12;
    for (int c = 0; c < SMAX; c++) run_cycle("wd_stall");
`ifdef YSYX_22051013_SB_WATCHDOG_EN
    chk("wd.timeout_set", 64'(sb_timeout), 1);
`endif
    idle();
    run_cycle("wd_release");
`ifdef YSYX_22051013_SB_WATCHDOG_EN
    chk("wd.timeout_sticky", 64'(sb_timeout), 1);
`endif
    chk("wd.busy12_held", 64'(busy_o[12]), 1);
    #1 rst = 0;
    #1;
    chk("async_rst.busy", 64'(busy_o), 0);
    chk("async_rst.timeout", 64'(sb_timeout), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1;

    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      rs1_ena  = $urandom_range(0, 1); rs1_addr = 5'($urandom_range(0, 7));
      rs2_ena  = $urandom_range(0, 1); rs2_addr = 5'($urandom_range(0, 7));
      rd_ena   = $urandom_range(0, 1); rd_addr  = 5'($urandom_range(0, 7));
      long_op  = $urandom_range(0, 1);
      rs1_rdata = {$urandom, $urandom}; rs2_rdata = {$urandom, $urandom};
      fwd_valid = 3'($urandom); fwd_pending = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        fa[i] = 5'($urandom_range(0, 7)); fd[i] = {$urandom, $urandom};
      end
      lw_done = ($urandom_range(0, 3) == 0); lw_addr = 5'($urandom_range(0, 7));
      lw_data = {$urandom, $urandom};
      run_cycle($sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_id_scoreboard.md
# ysyx_22051013_id_scoreboard

Parametrised operand-resolution and hazard unit for the ID stage of the ysyx_22051013 pipelined RV64 core. It generalises ID-stage forwarding to NFWD priority-ordered bypass channels. It adds a per-register busy scoreboard for long-latency writers (load miss, MUL/DIV, CSR), which lets those units complete out of the pipeline. It drives resolved op1/op2 to ID branch compare and to EX, and gates the ID→EX issue handshake.

## Interface
- XLEN, 64, datapath width
- NREG, 32, architectural registers; reg 0 hardwired zero
- NFWD, 3, bypass channels; channel 0 = youngest, highest priority
- STALL_MAX, 255, watchdog threshold in cycles; only used with watchdog
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- ex_ready  in  1  EX can accept
- flush  in  1  kill the ID instruction this cycle; no issue
- id_fire  out  1  instruction issued this cycle
- id_stall  out  1  hazard-blocked; ID must hold
- rs1_ena, rs2_ena  in  1  operand used
- rs1_addr, rs2_addr  in  $clog2(NREG)  source regs
- rs1_rdata, rs2_rdata  in  XLEN  regfile read data
- rd_ena  in  1  instruction writes rd
- rd_addr  in  $clog2(NREG)  destination
- long_op  in  1  rd is written by a long-latency unit
- fwd_valid  in  NFWD  channel carries a write to fwd_addr
- fwd_pending  in  NFWD  channel's result not yet available (load in EX, CSR)
- fwd_addr  in  NFWD*$clog2(NREG)  packed channel addresses
- fwd_data  in  NFWD*XLEN  packed channel data
- lw_done  in  1  long-latency writeback this cycle
- lw_addr  in  $clog2(NREG)  its destination
- lw_data  in  XLEN  its result
- op1, op2  out  XLEN  resolved operands; 0 when the operand is disabled
- busy_o  out  NREG  scoreboard snapshot
- sb_timeout  out  1  watchdog flag; tied 0 without the macro

## Operation
- busy[NREG] register, reset all 0; busy[0] is always 0.
- Operand resolution, per rs with ena=1 and addr≠0, in priority order:
  1. lowest-index fwd channel with valid and addr match → fwd_data
  2. lw_done & lw_addr match → lw_data
  3. rs_rdata
- Disabled operand or addr 0 → 0.
- RAW stall, per rs: the operand is enabled, addr≠0, and either:
  - the selected fwd channel has pending=1, or
  - busy[rs]=1 and no lw bypass matches it.
- WAW stall: rd_ena & rd_addr≠0 & busy[rd_addr] & no lw_done match on rd_addr. Applies to short ops too, so a fwd channel never targets a busy reg.
- id_stall = id_valid & (RAW | WAW) & ~flush.
- id_fire = id_valid & ~id_stall & ex_ready & ~flush.
- Set: id_fire & long_op & rd_ena & rd_addr≠0 → busy[rd_addr] ← 1 next edge.
- Clear: lw_done → busy[lw_addr] ← 0 next edge.
- Set and clear of the same reg in one cycle: set wins, because the issuing instruction is younger.
- lw_done on a non-busy reg: ignored, no error.
- flush never clears busy bits. Branches resolve in ID, so everything past ID is non-speculative.

## Timing
- op1/op2, id_stall and id_fire are combinational from inputs and busy; zero-cycle latency.
- busy updates on the rising clk edge after the set/clear cycle.
- An instruction stalled on busy[r] issues in the same cycle lw_done hits r, taking lw_data via bypass.
- Reset (async assert, sync release): busy=0, watchdog count=0, sb_timeout=0. A reset mid-operation drops all outstanding tracking.

## Configuration
- YSYX_22051013_SB_WATCHDOG_EN defined:
  - count increments each cycle id_stall=1 and clears when id_stall=0.
  - Reaching STALL_MAX sets sticky sb_timeout, which holds until reset.
  - count saturates at STALL_MAX.
- Macro undefined: no counter; sb_timeout tied 0.

## Structure
- Shared define/package: reg-address width, ZERO64, and the priority/channel-packing constants alongside existing pip_cpu defines.
- One sub-module: ysyx_22051013_sb_fwd_sel. It handles one operand's priority select plus pending/hit outputs and is instantiated twice (rs1, rs2). Scoreboard and watchdog stay in the top.

## Test plan
- Fwd priority, NFWD=3: rs1=5; ch0 and ch2 both target x5 with data 0xA and 0xC, none pending → op1=0xA, id_stall=0.
- Load-use: ch0 valid, addr 7, pending=1; rs2=7 → id_stall=1, id_fire=0. Drop pending with data 0x55 → op2=0x55, id_fire=1.
- Long op: issue DIV rd=x9 with long_op → busy[9]=1 next cycle. A consumer of x9 stalls. Assert lw_done for x9 with 0x1234 → consumer fires the same cycle with op1=0x1234, and busy[9]=0 next cycle.
- WAW and same-cycle set/clear:
  - A short op writing busy x3 stalls.
  - A long op to x3 issued in the cycle lw_done clears x3 → busy[3] stays 1.
- x0 and flush:
  - rs1=0 with a matching fwd channel → op1=0, no stall.
  - flush=1 with a pending hazard → id_stall=0, id_fire=0, busy unchanged.
- Watchdog (macro on, STALL_MAX=4): hold a busy-reg stall 4 cycles → sb_timeout=1 and stays 1 after the stall clears; async rst low → sb_timeout=0 and busy_o=0 immediately.
